spm_arbiter: RTL

- Shares the single-port scratchpad memory (SPM) between two requesters.
- Port 0 is the CPU data side: load/store traffic from the memory-control stage.
- Port 1 is the external loader/debug DMA port.
- Arbitration is fixed-priority to port 0 with an anti-starvation override for port 1.
- Read data returns one cycle after grant, with per-port valid. The block also raises the CPU stall request when port 0 loses arbitration.

---
 rtl/spm_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/spm_arbiter.sv
// Two-port arbiter for the single-port scratchpad.
// Port 0 (CPU data) has fixed priority. Port 1 (DMA/loader) is forced to win
// after STARVE_LIMIT consecutive denied cycles.
module spm_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned SPM_AW       = 12,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [31:0]       p0_wdata,
    input  logic [3:0]        p0_byteena,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p1_wdata,
    input  logic [3:0]        p1_byteena,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [31:0]       rdata,
    output logic              cpu_stall,
    output logic              spm_en,
    output logic              spm_we,
    output logic [SPM_AW-1:0] spm_addr,
    output logic [31:0]       spm_wdata,
    output logic [3:0]        spm_byteena,
    input  logic [31:0]       spm_rd_data,
    output logic [15:0]       conflict_cnt
);

    typedef enum logic [1:0] {
        OwnNone = 2'd0,
        OwnP0   = 2'd1,
        OwnP1   = 2'd2
    } owner_e;

    localparam logic [3:0] StarveLimit = 4'(STARVE_LIMIT);

    logic [3:0]  wait_cnt_q, wait_cnt_d;
    owner_e      rd_owner_q, rd_owner_d;
    logic [15:0] conflict_cnt_q, conflict_cnt_d;
    logic        force1;

    // Byte offset and out-of-range upper bits are deliberately ignored.
    logic unused_addr;
    assign unused_addr = ^{p0_addr[1:0], p0_addr[ADDR_W-1:SPM_AW+2],
                           p1_addr[1:0], p1_addr[ADDR_W-1:SPM_AW+2]};

    assign force1    = (wait_cnt_q == StarveLimit);
    assign p0_gnt    = p0_req && !(force1 && p1_req);
    assign p1_gnt    = p1_req && (!p0_req || force1);
    assign cpu_stall = p0_req && !p0_gnt;

    assign p0_rvalid    = (rd_owner_q == OwnP0);
    assign p1_rvalid    = (rd_owner_q == OwnP1);
    assign rdata        = spm_rd_data;
    assign conflict_cnt = conflict_cnt_q;

    // Route the granted port onto the SPM; reads always enable all bytes.
    always_comb begin
        spm_en      = p0_gnt | p1_gnt;
        spm_we      = 1'b0;
        spm_addr    = '0;
        spm_wdata   = '0;
        spm_byteena = '0;
        if (p0_gnt) begin
            spm_we      = p0_we;
            spm_addr    = p0_addr[SPM_AW+1:2];
            spm_wdata   = p0_wdata;
            spm_byteena = p0_we ? p0_byteena : 4'b1111;
        end else if (p1_gnt) begin
            spm_we      = p1_we;
            spm_addr    = p1_addr[SPM_AW+1:2];
            spm_wdata   = p1_wdata;
            spm_byteena = p1_we ? p1_byteena : 4'b1111;
        end
    end

    // Next-state: starvation counter, read-return owner, conflict counter.
    always_comb begin
        wait_cnt_d     = wait_cnt_q;
        rd_owner_d     = OwnNone;
        conflict_cnt_d = conflict_cnt_q;

        if (p1_gnt || !p1_req) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q != StarveLimit) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end

        if (p0_gnt && !p0_we) begin
            rd_owner_d = OwnP0;
        end else if (p1_gnt && !p1_we) begin
            rd_owner_d = OwnP1;
        end

        if (p0_req && p1_req && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    // State registers; reset drops any pending read return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q     <= 4'd0;
            rd_owner_q     <= OwnNone;
            conflict_cnt_q <= 16'd0;
        end else begin
            wait_cnt_q     <= wait_cnt_d;
            rd_owner_q     <= rd_owner_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

endmodule
